vector_reverse_stream: RTL and testbench
========================================

Name: vector_reverse_stream

Overview:
- Streaming, parametrised successor to the 8-bit combinational bit-order reverser.
- Accepts WIDTH-bit words over a valid/ready handshake and applies one of four run-time-selectable reorder modes. Modes are bit reverse, group reverse, and reverse-within-group, with GROUP-bit groups.
- Results are buffered in a DEPTH-entry FIFO and presented on a valid/ready output.
- Sits between a producer and consumer that both need backpressure; also keeps a wrapping transfer counter for debug.

Parameters:
- WIDTH, 8: data width in bits. Must be a multiple of GROUP and at least 2.
- GROUP, 4: group size in bits for modes 2 and 3. Must divide WIDTH; 1 ≤ GROUP ≤ WIDTH.
- DEPTH, 2: number of output buffer entries, ≥ 1.
- CNT_W, 16: width of the accepted-word counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  input word.
- mode  in  2  reorder mode, sampled with each accepted word.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  WIDTH  transformed word (FIFO head).
- level  out  clog2(DEPTH+1)  current occupancy.
- xfer_count  out  CNT_W  number of words accepted since reset, wrapping.

Behaviour:
- Reset (async assert, sync release): FIFO empty, level=0, out_valid=0, out_data=0, xfer_count=0, in_ready=1.
- Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Transform is applied combinationally at the input and the result is stored. A later mode change never alters stored words.
- Mode 0 passes the word through unchanged.
- Mode 1 reverses all bits: out[i] = in[WIDTH-1-i].
- Mode 2 reverses group order: group k → group (WIDTH/GROUP-1-k), with bits kept in order within each group.
- Mode 3 reverses bits within each group and keeps group positions. This equals mode 1 followed by mode 2.
- Degenerate parameters:
  - GROUP=1: mode 2 equals mode 1, and mode 3 equals mode 0.
  - GROUP=WIDTH: mode 2 equals mode 0, and mode 3 equals mode 1.
- Latency: an accepted word is visible on out_data/out_valid on the next rising edge. There is no combinational in→out path.
- in_ready = (level < DEPTH) || (out_ready && out_valid). This allows a full FIFO to accept while popping, for 1 word/cycle sustained throughput.
  - in_ready's only combinational input is out_ready.
  - in_ready must not depend on in_valid.
- out_valid = (level != 0), driven from registers only.
- out_data is stable while out_valid && !out_ready. A new accept never disturbs the head.
- Simultaneous accept and pop: level is unchanged, the head advances, and the new word goes to the tail.
  - At level=1, the new word becomes the head on the next edge.
- Read/write pointers wrap modulo DEPTH and must handle non-power-of-2 DEPTH.
- Empty: a pop is impossible (out_valid=0), and out_ready is ignored.
- Full with out_ready=0: in_ready=0 and in_data is ignored.
- xfer_count increments by 1 on every accept and wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-transfer discards all buffered words immediately (async). No partial word survives.
- X on in_data when in_valid=0 must not propagate to any output.

Test Plan:
- Mode sweep, WIDTH=8 GROUP=4, out_ready=1, in_data=0x12:
  - mode0 → 0x12, mode1 → 0x48, mode2 → 0x21, mode3 → 0x84.
  - Each result appears one cycle after accept.
- Legacy equivalence, mode 1, back-to-back words 0x01, 0x02, 0x04, 0x08, 0x80, 0xC0, 0xE0, 0xF0:
  - outputs are 0x80, 0x40, 0x20, 0x10, 0x01, 0x03, 0x07, 0x0F, one per cycle, with no bubbles.
- Backpressure, DEPTH=2, out_ready=0:
  - Push 0xAA then 0x55 in mode 0; a third word sees in_ready=0, level=2, and out_data held at 0xAA.
  - Then raise out_ready with in_valid=1 and data 0x0F: accept and pop occur in the same cycle, level stays 2, and order out is 0xAA, 0x55, 0x0F.
- Mode captured per word: accept 0x12 in mode 1, then change mode to 2 while the word is stalled → out_data remains 0x48.
- Counter wrap with CNT_W=4: after 17 accepts xfer_count=1. Cycles with in_valid=1 and in_ready=0 do not count.
- Async reset: with 2 words buffered, pulse rst_n low between clock edges → out_valid, level and xfer_count drop to 0 immediately, with no clock edge required. After release, the first new word 0x01 in mode 1 yields 0x80.

Source files
------------

// File: rtl/vector_reverse_stream_if.sv
// Handshake bundle for vector_reverse_stream: input stream, output stream, mode select.
interface vector_reverse_stream_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Producer/consumer side (drives words in, takes words out)
    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Block side
    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/vector_reverse_stream.sv
// Streaming bit/group reorder with a small output FIFO and a wrapping accept counter.
// Each accepted word is transformed at the input using the mode sampled with it,
// so later mode changes never touch words already buffered.
module vector_reverse_stream #(
    parameter int WIDTH = 8,
    parameter int GROUP = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    vector_reverse_stream_if.slave       bus,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [CNT_W-1:0]             xfer_count
);
    localparam int NGRP  = WIDTH / GROUP;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Apply one of the four reorder modes to a word.
    function automatic logic [WIDTH-1:0] reorder(input logic [WIDTH-1:0] d,
                                                 input logic [1:0]       m);
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            2'd1: begin
                for (int i = 0; i < WIDTH; i++)
                    r[i] = d[WIDTH-1-i];
            end
            2'd2: begin
                for (int g = 0; g < NGRP; g++)
                    for (int b = 0; b < GROUP; b++)
                        r[g*GROUP+b] = d[(NGRP-1-g)*GROUP+b];
            end
            2'd3: begin
                for (int g = 0; g < NGRP; g++)
                    for (int b = 0; b < GROUP; b++)
                        r[g*GROUP+b] = d[g*GROUP+GROUP-1-b];
            end
            default: r = d;
        endcase
        return r;
    endfunction

    // Pointer increment that wraps at DEPTH (works for non-power-of-2 depths).
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] xf_data_p0;
    logic             vld_p0;
    logic             push;
    logic             pop;

    // Handshake decode and input transform; in_ready depends only on out_ready and state.
    always_comb begin
        vld_p0       = (level != '0);
        bus.out_valid = vld_p0;
        bus.in_ready = (level < LVL_W'(DEPTH)) || (bus.out_ready && vld_p0);
        push         = bus.in_valid && bus.in_ready;
        pop          = vld_p0 && bus.out_ready;
        xf_data_p0   = reorder(bus.in_data, bus.mode);
        // Empty FIFO presents zero so unwritten storage never reaches the output.
        bus.out_data = vld_p0 ? mem[rd_ptr] : '0;
    end

    // ---- stage p0 -> FIFO storage ----
    // Storage is written only on accept; it carries no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= xf_data_p0;
    end

    // Pointers, occupancy and accept counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            xfer_count <= '0;
        end else begin
            if (push) begin
                wr_ptr     <= ptr_next(wr_ptr);
                xfer_count <= xfer_count + CNT_W'(1);
            end
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_reverse_stream.sv
// Bench for vector_reverse_stream (WIDTH=8, GROUP=4, DEPTH=2, CNT_W=4):
// table-driven mode sweep, directed corner sequences, then randomized traffic
// against a queue-based reference model.
module tb_vector_reverse_stream;
    logic       clk;
    logic       rst_n;
    logic [2:0] level;
    logic [3:0] xfer_count;
    int         tests;
    int         fails;

    vector_reverse_stream_if #(.WIDTH(8)) bus ();

    vector_reverse_stream #(
        .WIDTH(8), .GROUP(4), .DEPTH(2), .CNT_W(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .level      (level),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference transforms, from the reorder rules for an 8-bit word with 4-bit groups.
    function automatic logic [7:0] m_rev(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = x[i];
        return r;
    endfunction

    function automatic logic [7:0] m_swap(input logic [7:0] x);
        return {x[3:0], x[7:4]};
    endfunction

    function automatic logic [7:0] model_xf(input logic [7:0] x, input logic [1:0] m);
        case (m)
            2'd0:    return x;
            2'd1:    return m_rev(x);
            2'd2:    return m_swap(x);
            default: return m_swap(m_rev(x));
        endcase
    endfunction

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
        bus.mode     = 'x;
    endtask

    task automatic drive(input logic [7:0] d, input logic [1:0] m);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.mode     = m;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl[9];
    logic [7:0] leg_in  [8];
    logic [7:0] leg_exp [8];
    logic [7:0] q[$];
    logic [3:0] cnt;

    initial begin
        tbl[0] = '{2'd0, 8'h12, 8'h12};
        tbl[1] = '{2'd1, 8'h12, 8'h48};
        tbl[2] = '{2'd2, 8'h12, 8'h21};
        tbl[3] = '{2'd3, 8'h12, 8'h84};
        tbl[4] = '{2'd3, 8'hA5, 8'h5A};
        tbl[5] = '{2'd2, 8'hA5, 8'h5A};
        tbl[6] = '{2'd1, 8'hA5, 8'hA5};
        tbl[7] = '{2'd3, 8'h1E, 8'h87};
        tbl[8] = '{2'd1, 8'h01, 8'h80};
        leg_in  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h80, 8'hC0, 8'hE0, 8'hF0};
        leg_exp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h01, 8'h03, 8'h07, 8'h0F};
        tests = 0;
        fails = 0;

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_xfer_count", 32'(xfer_count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // Mode sweep table: result one cycle after accept
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            drive(tbl[i].din, tbl[i].mode);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("tbl%0d_data", i), 32'(bus.out_data), 32'(tbl[i].exp));
            idle_inputs();
            @(negedge clk);
            chk($sformatf("tbl%0d_drain", i), 32'(level), 32'd0);
        end

        // Legacy equivalence, back-to-back with no bubbles
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("leg%0d_valid", i-1), 32'(bus.out_valid), 32'd1);
                chk($sformatf("leg%0d_data", i-1), 32'(bus.out_data), 32'(leg_exp[i-1]));
            end
            if (i < 8) begin
                chk($sformatf("leg%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
                drive(leg_in[i], 2'd1);
            end else begin
                idle_inputs();
            end
        end
        @(negedge clk);
        chk("leg_empty", 32'(level), 32'd0);

        // Backpressure: fill, stall third word, then accept+pop together
        bus.out_ready = 1'b0;
        drive(8'hAA, 2'd0);
        @(negedge clk);
        drive(8'h55, 2'd0);
        @(negedge clk);
        drive(8'h33, 2'd0);
        #1;
        chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("bp_level_full", 32'(level), 32'd2);
        chk("bp_head", 32'(bus.out_data), 32'hAA);
        @(negedge clk);
        chk("bp_head_held", 32'(bus.out_data), 32'hAA);
        chk("bp_level_held", 32'(level), 32'd2);
        bus.out_ready = 1'b1;
        drive(8'h0F, 2'd0);
        #1;
        chk("bp_in_ready_pop", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("bp_level_same", 32'(level), 32'd2);
        chk("bp_out1", 32'(bus.out_data), 32'h55);
        idle_inputs();
        @(negedge clk);
        chk("bp_out2", 32'(bus.out_data), 32'h0F);
        @(negedge clk);
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // Mode captured with the word, not at output time
        bus.out_ready = 1'b0;
        drive(8'h12, 2'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.mode     = 2'd2;
        @(negedge clk);
        @(negedge clk);
        chk("modecap_data", 32'(bus.out_data), 32'h48);
        bus.out_ready = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("modecap_drain", 32'(level), 32'd0);

        // Counter wrap with CNT_W=4; stalled cycles do not count
        do_reset();
        @(negedge clk);
        drive(8'h01, 2'd0);
        @(negedge clk);
        drive(8'h02, 2'd0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("cnt_stalled", 32'(xfer_count), 32'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(8'(i), 2'd0);
            @(negedge clk);
        end
        idle_inputs();
        chk("cnt_wrap", 32'(xfer_count), 32'd1);
        @(negedge clk);
        @(negedge clk);

        // Async reset with two words buffered, between clock edges
        bus.out_ready = 1'b0;
        drive(8'h11, 2'd0);
        @(negedge clk);
        drive(8'h22, 2'd0);
        @(negedge clk);
        idle_inputs();
        chk("ar_level_before", 32'(level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_level", 32'(level), 32'd0);
        chk("ar_xfer_count", 32'(xfer_count), 32'd0);
        chk("ar_out_data", 32'(bus.out_data), 32'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(8'h01, 2'd1);
        @(negedge clk);
        idle_inputs();
        chk("ar_first_word", 32'(bus.out_data), 32'h80);
        chk("ar_first_count", 32'(xfer_count), 32'd1);

        // Randomized traffic against a queue model
        do_reset();
        q.delete();
        cnt = '0;
        for (int c = 0; c < 400; c++) begin
            logic       v, r, exp_rdy;
            logic [7:0] d;
            logic [1:0] m;
            @(negedge clk);
            v = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            m = 2'($urandom);
            bus.out_ready = r;
            if (v) drive(d, m);
            else   idle_inputs();
            #1;
            exp_rdy = (q.size() < 2) || (r && q.size() > 0);
            chk("rnd_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            chk("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            chk("rnd_level", 32'(level), 32'(q.size()));
            chk("rnd_out_data", 32'(bus.out_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
            chk("rnd_xfer_count", 32'(xfer_count), 32'(cnt));
            @(posedge clk);
            if (r && q.size() > 0) void'(q.pop_front());
            if (v && exp_rdy) begin
                q.push_back(model_xf(d, m));
                cnt = cnt + 4'd1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
